// File: rtl/imgproc_bgsub_param_pkg.sv
// Shared types for the background-subtraction engine: lane modes and FSM states.
// Pure declarations, no logic or latency of its own.
package imgproc_bgsub_param_pkg;

  typedef enum logic [1:0] {
    MODE_ABS   = 2'd0,
    MODE_CLAMP = 2'd1,
    MODE_MASK  = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/imgproc_bgsub_param_if.sv
// Host/BRAM-facing bundle of the engine; slave is the engine, master is the host plus memories.
// No latency; start/busy is the only flow control and there is no write backpressure.
interface imgproc_bgsub_param_if #(
  parameter int PIX_W   = 8,
  parameter int LANES   = 16,
  parameter int ADDR_W  = 13,
  parameter int FRAME_W = 3,
  parameter int CNT_W   = 16
);
  logic                     start;
  logic [1:0]               mode;
  logic [PIX_W-1:0]         thresh;
  logic [PIX_W*LANES-1:0]   readPixel;
  logic [PIX_W*LANES-1:0]   bgPixel;
  logic [ADDR_W-1:0]        readAddress;
  logic [ADDR_W-1:0]        writeAddress;
  logic [PIX_W*LANES-1:0]   subtractedPixel;
  logic                     writeEn;
  logic [FRAME_W-1:0]       currentFrame;
  logic [CNT_W-1:0]         goodCnt;
  logic [CNT_W-1:0]         badCnt;
  logic                     busy;
  logic                     frameDone;

  modport master (
    output start, mode, thresh, readPixel, bgPixel,
    input  readAddress, writeAddress, subtractedPixel, writeEn,
           currentFrame, goodCnt, badCnt, busy, frameDone
  );

  modport slave (
    input  start, mode, thresh, readPixel, bgPixel,
    output readAddress, writeAddress, subtractedPixel, writeEn,
           currentFrame, goodCnt, badCnt, busy, frameDone
  );
endinterface

// File: rtl/imgproc_bgsub_param_lane_diff.sv
// One pixel lane: frame minus background under the selected mode, plus bad-lane flag.
// Purely combinational; no backpressure.
module imgproc_bgsub_param_lane_diff
  import imgproc_bgsub_param_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic [PIX_W-1:0] pix,
  input  logic [PIX_W-1:0] bg,
  input  logic [PIX_W-1:0] thresh,
  input  mode_t            mode,
  output logic [PIX_W-1:0] result,
  output logic             isBad
);

  logic [PIX_W-1:0] absDiff;

  // Classification is always on the absolute difference, whatever the output mode.
  always_comb begin
    absDiff = (pix > bg) ? (pix - bg) : (bg - pix);
    isBad   = (absDiff > thresh);
    result  = '0;
    case (mode)
      MODE_ABS:   result = absDiff;
      MODE_CLAMP: result = (pix > bg) ? (pix - bg) : '0;
      MODE_MASK:  result = isBad ? '1 : '0;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/imgproc_bgsub_param.sv
// Frame-pass background subtraction: streams NUM_WORDS words, writes results, counts good/bad lanes.
// Results READ_LAT+1 cycles after each read address; start accepted only when idle, no backpressure.
module imgproc_bgsub_param
  import imgproc_bgsub_param_pkg::*;
#(
  parameter int PIX_W     = 8,
  parameter int LANES     = 16,
  parameter int ADDR_W    = 13,
  parameter int NUM_WORDS = 8192,
  parameter int READ_LAT  = 1,
  parameter int FRAME_W   = 3,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rstN,
  imgproc_bgsub_param_if.slave  bus
);

  localparam int WORD_W = PIX_W * LANES;
  localparam int PC_W   = $clog2(LANES + 1);
  localparam int SUM_W  = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t              state, stateNext;
  logic [ADDR_W-1:0]   addr;
  logic [2:0]          drainCnt;
  mode_t               modeReg;
  logic [PIX_W-1:0]    threshReg;
  logic [READ_LAT-1:0] vldPipe;
  logic [ADDR_W-1:0]   addrPipe [READ_LAT];
  logic [WORD_W-1:0]   laneRes;
  logic [LANES-1:0]    laneBad;
  logic [PC_W-1:0]     badPop;
  logic [CNT_W-1:0]    goodAcc, badAcc;
  logic [CNT_W-1:0]    goodCntReg, badCntReg;
  logic [FRAME_W-1:0]  frameReg;
  logic [ADDR_W-1:0]   wrAddrReg;
  logic [WORD_W-1:0]   wrDataReg;
  logic                wrEnReg;
  logic                doneReg;
  logic                startAcc;

  function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] a, input logic [PC_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    return (s > SUM_W'(CNT_MAX)) ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  for (genvar g = 0; g < LANES; g++) begin : genLane
    imgproc_bgsub_param_lane_diff #(.PIX_W(PIX_W)) uLane (
      .pix    (bus.readPixel[g*PIX_W +: PIX_W]),
      .bg     (bus.bgPixel[g*PIX_W +: PIX_W]),
      .thresh (threshReg),
      .mode   (modeReg),
      .result (laneRes[g*PIX_W +: PIX_W]),
      .isBad  (laneBad[g])
    );
  end

  always_comb begin
    badPop = '0;
    for (int i = 0; i < LANES; i++) badPop = badPop + PC_W'(laneBad[i]);
  end

  assign startAcc = (state == ST_IDLE) && bus.start;

  always_ff @(posedge clk) begin
    if (!rstN) state <= ST_IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE:  if (bus.start) stateNext = ST_RUN;
      ST_RUN:   if (addr == LAST_ADDR) stateNext = ST_DRAIN;
      ST_DRAIN: if (drainCnt == 3'(READ_LAT)) stateNext = ST_DONE;
      ST_DONE:  stateNext = ST_IDLE;
      default:  stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      addr       <= '0;
      drainCnt   <= '0;
      modeReg    <= MODE_ABS;
      threshReg  <= '0;
      vldPipe    <= '0;
      for (int i = 0; i < READ_LAT; i++) addrPipe[i] <= '0;
      wrEnReg    <= 1'b0;
      wrAddrReg  <= '0;
      wrDataReg  <= '0;
      goodAcc    <= '0;
      badAcc     <= '0;
      goodCntReg <= '0;
      badCntReg  <= '0;
      frameReg   <= '0;
      doneReg    <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      if (startAcc) begin
        addr      <= '0;
        modeReg   <= mode_t'(bus.mode);
        threshReg <= bus.thresh;
      end else if (state == ST_RUN && addr != LAST_ADDR) begin
        addr <= addr + ADDR_W'(1);
      end
      drainCnt <= (state == ST_DRAIN) ? drainCnt + 3'd1 : 3'd0;

      // Address/valid delay line lines up with data returning from the BRAMs.
      vldPipe[0]  <= (state == ST_RUN);
      addrPipe[0] <= addr;
      for (int i = 1; i < READ_LAT; i++) begin
        vldPipe[i]  <= vldPipe[i-1];
        addrPipe[i] <= addrPipe[i-1];
      end

      wrEnReg <= vldPipe[READ_LAT-1];
      if (vldPipe[READ_LAT-1]) begin
        wrAddrReg <= addrPipe[READ_LAT-1];
        wrDataReg <= laneRes;
        goodAcc   <= satAdd(goodAcc, PC_W'(LANES) - badPop);
        badAcc    <= satAdd(badAcc, badPop);
      end

      // Pipeline is empty by the last drain cycle, so publishing here sees final sums.
      if (state == ST_DRAIN && stateNext == ST_DONE) begin
        goodCntReg <= goodAcc;
        badCntReg  <= badAcc;
        goodAcc    <= '0;
        badAcc     <= '0;
        frameReg   <= frameReg + FRAME_W'(1);
        doneReg    <= 1'b1;
      end
    end
  end

  assign bus.readAddress     = addr;
  assign bus.writeAddress    = wrAddrReg;
  assign bus.subtractedPixel = wrDataReg;
  assign bus.writeEn         = wrEnReg;
  assign bus.currentFrame    = frameReg;
  assign bus.goodCnt         = goodCntReg;
  assign bus.badCnt          = badCntReg;
  assign bus.frameDone       = doneReg;
  assign bus.busy            = (state != ST_IDLE);

endmodule

// File: tb/tb_imgproc_bgsub_param.sv
// Bench for imgproc_bgsub_param: 4-word frames, READ_LAT=1, a 16-bit and a 4-bit counter instance.
module tb_imgproc_bgsub_param;

  localparam int NW = 4;

  logic clk = 1'b0;
  logic rstN;
  int   passCnt = 0;
  int   totalCnt = 0;
  int   failCnt = 0;
  int   expFrame = 0;

  logic [127:0] frameMem [NW];
  logic [127:0] bgMem [NW];

  imgproc_bgsub_param_if #(.PIX_W(8), .LANES(16), .ADDR_W(13), .FRAME_W(3), .CNT_W(16)) busA ();
  imgproc_bgsub_param_if #(.PIX_W(8), .LANES(16), .ADDR_W(13), .FRAME_W(3), .CNT_W(4))  busB ();

  imgproc_bgsub_param #(.PIX_W(8), .LANES(16), .ADDR_W(13), .NUM_WORDS(NW), .READ_LAT(1),
                        .FRAME_W(3), .CNT_W(16)) dut (.clk(clk), .rstN(rstN), .bus(busA));
  imgproc_bgsub_param #(.PIX_W(8), .LANES(16), .ADDR_W(13), .NUM_WORDS(NW), .READ_LAT(1),
                        .FRAME_W(3), .CNT_W(4)) dutSat (.clk(clk), .rstN(rstN), .bus(busB));

  always #5 clk = ~clk;

  assign busB.start  = busA.start;
  assign busB.mode   = busA.mode;
  assign busB.thresh = busA.thresh;

  // One-cycle BRAMs shared by both instances.
  always @(posedge clk) begin
    busA.readPixel <= frameMem[busA.readAddress[1:0]];
    busA.bgPixel   <= bgMem[busA.readAddress[1:0]];
    busB.readPixel <= frameMem[busB.readAddress[1:0]];
    busB.bgPixel   <= bgMem[busB.readAddress[1:0]];
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] refWord(input logic [127:0] p, input logic [127:0] b,
                                           input int m, input int th);
    logic [127:0] r = '0;
    for (int i = 0; i < 16; i++) begin
      int pv = int'(p[i*8 +: 8]);
      int bv = int'(b[i*8 +: 8]);
      int d  = (pv > bv) ? pv - bv : bv - pv;
      int o  = 0;
      if (m == 0) o = d;
      else if (m == 1) o = (pv > bv) ? pv - bv : 0;
      else if (m == 2) o = (d > th) ? 255 : 0;
      r[i*8 +: 8] = 8'(o);
    end
    return r;
  endfunction

  function automatic int refBad(input logic [127:0] p, input logic [127:0] b, input int th);
    int n = 0;
    for (int i = 0; i < 16; i++) begin
      int pv = int'(p[i*8 +: 8]);
      int bv = int'(b[i*8 +: 8]);
      if (((pv > bv) ? pv - bv : bv - pv) > th) n++;
    end
    return n;
  endfunction

  function automatic int sat(input int v, input int maxV);
    return (v > maxV) ? maxV : v;
  endfunction

  // One frame pass, called at a negedge with the DUT idle; returns at the negedge of the idle cycle after DONE.
  task automatic runFrame(input int m, input int th, input bit hold, input bit poke);
    logic [127:0] expW [NW];
    int bad = 0;
    int good;
    int doneSeen = 0;
    for (int w = 0; w < NW; w++) begin
      expW[w] = refWord(frameMem[w], bgMem[w], m, th);
      bad += refBad(frameMem[w], bgMem[w], th);
    end
    good = NW * 16 - bad;
    busA.start  = 1'b1;
    busA.mode   = 2'(m);
    busA.thresh = 8'(th);
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (!hold) begin
        if (k == 1) busA.start = 1'b0;
        if (poke && k == 3) busA.start = 1'b1;
        if (poke && k == 4) busA.start = 1'b0;
      end
      check($sformatf("readAddress k%0d", k), busA.readAddress, (k <= NW) ? k - 1 : NW - 1);
      check($sformatf("busy k%0d", k), busA.busy, (k <= 7) ? 1 : 0);
      check($sformatf("writeEn k%0d", k), busA.writeEn, (k >= 3 && k <= 6) ? 1 : 0);
      if (k >= 3 && k <= 6) begin
        check($sformatf("writeAddress k%0d", k), busA.writeAddress, k - 3);
        check($sformatf("subtractedPixel w%0d", k - 3), busA.subtractedPixel, expW[k-3]);
      end
      if (busA.frameDone) doneSeen++;
      if (k == 7) begin
        expFrame = (expFrame + 1) % 8;
        check("frameDone", busA.frameDone, 1);
        check("goodCnt", busA.goodCnt, good);
        check("badCnt", busA.badCnt, bad);
        check("currentFrame", busA.currentFrame, expFrame);
        check("sat goodCnt", busB.goodCnt, sat(good, 15));
        check("sat badCnt", busB.badCnt, sat(bad, 15));
      end
    end
    check("frameDone pulses", doneSeen, 1);
  endtask

  task automatic fillFixed(input logic [127:0] p, input logic [127:0] b);
    for (int w = 0; w < NW; w++) begin
      frameMem[w] = p;
      bgMem[w]    = b;
    end
  endtask

  task automatic fillRandom();
    for (int w = 0; w < NW; w++) begin
      frameMem[w] = {$urandom, $urandom, $urandom, $urandom};
      bgMem[w]    = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  initial begin
    rstN        = 1'b0;
    busA.start  = 1'b1;
    busA.mode   = 2'd0;
    busA.thresh = 8'd0;
    fillFixed('0, '0);

    // T1 reset, with start asserted throughout
    repeat (2) @(negedge clk);
    rstN       = 1'b1;
    busA.start = 1'b0;
    @(negedge clk);
    check("rst readAddress", busA.readAddress, 0);
    check("rst writeAddress", busA.writeAddress, 0);
    check("rst subtractedPixel", busA.subtractedPixel, 0);
    check("rst writeEn", busA.writeEn, 0);
    check("rst currentFrame", busA.currentFrame, 0);
    check("rst goodCnt", busA.goodCnt, 0);
    check("rst badCnt", busA.badCnt, 0);
    check("rst busy", busA.busy, 0);
    check("rst frameDone", busA.frameDone, 0);

    // T2/T3 fixed words across all modes
    fillFixed(128'h01ff45008900cd0001ff45008900cd00, 128'h0123456789abcdef0123456789abcdef);
    runFrame(0, 8'h10, 1'b0, 1'b0);
    check("T2 word", busA.subtractedPixel, 128'h00dc006700ab00ef00dc006700ab00ef);
    check("T2 badCnt", busA.badCnt, 32);
    check("T2 goodCnt", busA.goodCnt, 32);
    check("T2 currentFrame", busA.currentFrame, 1);
    runFrame(1, 8'h10, 1'b0, 1'b1);
    check("T3 clamp word", busA.subtractedPixel, 128'h00dc000000000000_00dc000000000000);
    check("T3 clamp badCnt", busA.badCnt, 32);
    runFrame(2, 8'h10, 1'b0, 1'b0);
    check("T3 mask word", busA.subtractedPixel, 128'h00ff00ff00ff00ff_00ff00ff00ff00ff);
    check("T3 mask goodCnt", busA.goodCnt, 32);
    runFrame(3, 8'h10, 1'b0, 1'b0);
    check("T3 rsvd word", busA.subtractedPixel, 128'h0);

    // Randomized frames against the reference model
    for (int f = 0; f < 6; f++) begin
      fillRandom();
      runFrame(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), 1'b0, f[0]);
    end

    // T4 start held high for 9 back-to-back passes; currentFrame wraps along the way
    for (int f = 0; f < 9; f++) begin
      fillRandom();
      runFrame(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), 1'b1, 1'b0);
    end
    busA.start = 1'b0;

    // T5 reset while readAddress==2 aborts the pass
    @(negedge clk);
    fillRandom();
    busA.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    busA.start = 1'b0;
    repeat (2) @(negedge clk);
    check("T5 readAddress", busA.readAddress, 2);
    rstN = 1'b0;
    @(negedge clk);
    check("T5 writeEn", busA.writeEn, 0);
    check("T5 goodCnt", busA.goodCnt, 0);
    check("T5 badCnt", busA.badCnt, 0);
    check("T5 currentFrame", busA.currentFrame, 0);
    check("T5 busy", busA.busy, 0);
    rstN     = 1'b1;
    expFrame = 0;
    @(negedge clk);
    runFrame(0, int'($urandom_range(0, 255)), 1'b0, 1'b0);
    check("T5 restart currentFrame", busA.currentFrame, 1);

    // T6 every lane bad: 4-bit counter saturates
    fillFixed({16{8'hff}}, '0);
    runFrame(0, 0, 1'b0, 1'b0);
    check("T6 sat badCnt", busB.badCnt, 15);
    check("T6 sat goodCnt", busB.goodCnt, 0);
    check("T6 wide badCnt", busA.badCnt, 64);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
